mtr_duty_ctrl: RTL and testbench
================================

MTR_DUTY_CTRL -- requirements
Module: mtr_duty_ctrl

Interface
REQ-001 Parameter OVR_LIMIT, default 8, meaning: number of consecutive PWM periods with a qualified over-current event that trips shutdown (legal range 1..15).
REQ-002 clk  input  1  system clock (50 MHz); the single clock for all state.
REQ-003 rst_n  input  1  reset; synchronous, active-low, sampled on rising edge of clk.
REQ-004 spd  input  12  signed motor speed command from balance controller, two's complement.
REQ-005 PWM_synch  input  1  one-cycle pulse from downstream PWM stage marking the last clk of each 2048-clk PWM period.
REQ-006 OVR_I_blank_n  input  1  high when over-current sensing is valid in the current PWM period (low during early blanking window).
REQ-007 OVR_I  input  1  raw over-current flag from H-bridge, already synchronous to clk.
REQ-008 clr_fault  input  1  single-cycle request to leave shutdown.
REQ-009 duty  output  11  unsigned duty to downstream PWM stage; 11'h400 = zero torque.
REQ-010 pwm_en  output  1  H-bridge drive enable.
REQ-011 OVR_I_shtdwn  output  1  high while in shutdown or re-arm.
REQ-012 ovr_cnt  output  4  current consecutive over-current period count.

Function
REQ-013 Saturation: spd > 1023 -> 1023; spd < -1024 -> -1024; otherwise unchanged; result 11-bit signed.
REQ-014 Offset: duty_nxt = saturated value + 11'h400, taken modulo 2^11 (range 0..2047; -1024 -> 0, 0 -> 1024, 1023 -> 2047).
REQ-015 duty register loads duty_nxt only on a clk where PWM_synch=1 and state is RUN; otherwise holds; spd changes mid-period never alter duty before next PWM_synch.
REQ-016 Latency: spd stable at PWM_synch edge -> duty valid on following clk (1 cycle after the PWM_synch clk).
REQ-017 State machine states RUN, FAULT, REARM; reset state RUN.
REQ-018 Period flag ovr_seen sets on any clk with OVR_I=1 and OVR_I_blank_n=1; OVR_I while OVR_I_blank_n=0 is ignored.
REQ-019 On PWM_synch clk: if ovr_seen (including an event on that same clk) then ovr_cnt increments, else ovr_cnt clears to 0; ovr_seen clears in both cases.
REQ-020 ovr_cnt saturates at 15, never wraps.
REQ-021 RUN -> FAULT on the clk where the increment makes ovr_cnt equal OVR_LIMIT; duty forced to 11'h400 and pwm_en=0 on the next clk.
REQ-022 FAULT: duty held 11'h400, pwm_en=0, OVR_I_shtdwn=1, ovr_cnt and ovr_seen held at 0 (cleared on entry); OVR_I ignored.
REQ-023 FAULT -> REARM on clr_fault=1; clr_fault in RUN or REARM has no effect.
REQ-024 REARM: outputs as FAULT; -> RUN on next PWM_synch, on which clk duty loads duty_nxt per REQ-015 and pwm_en rises next clk.
REQ-025 In RUN pwm_en=1, OVR_I_shtdwn=0.
REQ-026 clr_fault and PWM_synch on same clk while in FAULT: go to REARM only; RUN requires a later PWM_synch.

Reset
REQ-027 rst_n=0 at a clk edge: state RUN, duty=11'h400, pwm_en=1, OVR_I_shtdwn=0, ovr_cnt=0, ovr_seen=0, regardless of current state (including mid-FAULT or mid-period).
REQ-028 After reset release, duty updates only at first subsequent PWM_synch.

Verification
REQ-029 spd=12'h7FF, then PWM_synch -> duty=11'h7FF next clk; spd=12'h800 -> duty=11'h000; spd=12'h000 -> 11'h400; spd=12'hC00 (-1024) -> 11'h000.
REQ-030 spd changed mid-period without PWM_synch -> duty unchanged for 2047 clks until after next PWM_synch.
REQ-031 OVR_I=1 only while OVR_I_blank_n=0 for 20 periods -> ovr_cnt stays 0, pwm_en stays 1.
REQ-032 Qualified OVR_I in 8 consecutive periods (OVR_LIMIT=8) -> OVR_I_shtdwn=1, pwm_en=0, duty=11'h400 one clk after 8th PWM_synch; 7 periods then one clean period -> ovr_cnt=0, no trip.
REQ-033 In FAULT pulse clr_fault -> REARM, outputs stay shutdown until next PWM_synch, then pwm_en=1 and duty=duty_nxt.
REQ-034 Assert rst_n=0 in FAULT with ovr_cnt nonzero history -> next clk RUN, duty=11'h400, ovr_cnt=0, OVR_I_shtdwn=0.

Source files
------------

// File: rtl/mtr_duty_ctrl.sv
// Motor duty controller: saturates and offsets the signed speed command into PWM duty,
// and trips into shutdown after OVR_LIMIT consecutive PWM periods with qualified over-current.
module mtr_duty_ctrl #(
  parameter int unsigned OVR_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] spd,
  input  logic        PWM_synch,
  input  logic        OVR_I_blank_n,
  input  logic        OVR_I,
  input  logic        clr_fault,
  output logic [10:0] duty,
  output logic        pwm_en,
  output logic        OVR_I_shtdwn,
  output logic [3:0]  ovr_cnt
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFault = 2'd1,
    StRearm = 2'd2
  } state_e;

  localparam logic [10:0] DutyZero = 11'h400;
  localparam logic [3:0]  Limit    = 4'(OVR_LIMIT);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [10:0] r_duty;
  logic [10:0] w_duty_d;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_d;
  logic        r_seen;
  logic        w_seen_d;

  logic [10:0] w_sat;
  logic [10:0] w_duty_nxt;
  logic        w_seen_any;
  logic [3:0]  w_cnt_inc;

  // Overflow is detected from the sign bit disagreeing with bit 10.
  always_comb begin
    unique case (spd[11:10])
      2'b01:   w_sat = 11'h3FF;
      2'b10:   w_sat = 11'h400;
      default: w_sat = spd[10:0];
    endcase
    w_duty_nxt = w_sat + DutyZero;
  end

  // An event on the PWM_synch clk itself still counts for the closing period.
  assign w_seen_any = r_seen | (OVR_I & OVR_I_blank_n);
  assign w_cnt_inc  = (r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_duty_d    = r_duty;
    w_cnt_d     = r_cnt;
    w_seen_d    = r_seen;
    case (r_state)
      StRun: begin
        w_seen_d = w_seen_any;
        if (PWM_synch) begin
          w_seen_d = 1'b0;
          w_cnt_d  = w_seen_any ? w_cnt_inc : 4'd0;
          if (w_seen_any && (w_cnt_inc == Limit)) begin
            w_state_nxt = StFault;
            w_cnt_d     = 4'd0;
            w_duty_d    = DutyZero;
          end else begin
            w_duty_d = w_duty_nxt;
          end
        end
      end
      StFault: begin
        w_cnt_d  = 4'd0;
        w_seen_d = 1'b0;
        w_duty_d = DutyZero;
        if (clr_fault) begin
          w_state_nxt = StRearm;
        end
      end
      StRearm: begin
        w_cnt_d  = 4'd0;
        w_seen_d = 1'b0;
        if (PWM_synch) begin
          w_state_nxt = StRun;
          w_duty_d    = w_duty_nxt;
        end
      end
      default: begin
        w_state_nxt = StRun;
        w_duty_d    = DutyZero;
        w_cnt_d     = 4'd0;
        w_seen_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_duty  <= DutyZero;
      r_cnt   <= 4'd0;
      r_seen  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_d;
      r_cnt   <= w_cnt_d;
      r_seen  <= w_seen_d;
    end
  end

  assign duty         = r_duty;
  assign pwm_en       = (r_state == StRun);
  assign OVR_I_shtdwn = (r_state != StRun);
  assign ovr_cnt      = r_cnt;

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Directed self-checking bench for mtr_duty_ctrl with hand-computed expectations.
module tb_mtr_duty_ctrl;

  logic        clk;
  logic        rst_n;
  logic [11:0] spd;
  logic        PWM_synch;
  logic        OVR_I_blank_n;
  logic        OVR_I;
  logic        clr_fault;
  logic [10:0] duty;
  logic        pwm_en;
  logic        OVR_I_shtdwn;
  logic [3:0]  ovr_cnt;

  int total;
  int bad;

  mtr_duty_ctrl #(.OVR_LIMIT(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spd          (spd),
    .PWM_synch    (PWM_synch),
    .OVR_I_blank_n(OVR_I_blank_n),
    .OVR_I        (OVR_I),
    .clr_fault    (clr_fault),
    .duty         (duty),
    .pwm_en       (pwm_en),
    .OVR_I_shtdwn (OVR_I_shtdwn),
    .ovr_cnt      (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clk and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic synch();
    PWM_synch = 1'b1;
    tick();
    PWM_synch = 1'b0;
  endtask

  // One short PWM period with a qualified over-current event, mid-period or on the synch clk.
  task automatic qual_period(input bit on_synch);
    idle(3);
    if (!on_synch) begin
      OVR_I = 1'b1;
      tick();
      OVR_I = 1'b0;
    end
    idle(2);
    if (on_synch) OVR_I = 1'b1;
    synch();
    OVR_I = 1'b0;
  endtask

  task automatic spd_case(input string tag, input logic [11:0] s, input logic [10:0] exp);
    spd = s;
    idle(2);
    synch();
    check(tag, int'(duty), int'(exp));
  endtask

  initial begin
    bit ok;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    spd           = 12'h7FF;
    PWM_synch     = 1'b0;
    OVR_I_blank_n = 1'b1;
    OVR_I         = 1'b0;
    clr_fault     = 1'b0;

    idle(2);
    check("rst_duty", int'(duty), 'h400);
    check("rst_pwm_en", int'(pwm_en), 1);
    check("rst_shtdwn", int'(OVR_I_shtdwn), 0);
    check("rst_cnt", int'(ovr_cnt), 0);
    rst_n = 1'b1;
    idle(5);
    check("no_update_before_synch", int'(duty), 'h400);
    synch();
    check("spd_7ff", int'(duty), 'h7FF);

    spd_case("spd_800", 12'h800, 11'h000);
    spd_case("spd_000", 12'h000, 11'h400);
    spd_case("spd_c00", 12'hC00, 11'h000);
    spd_case("spd_123", 12'h123, 11'h523);
    spd_case("spd_f00", 12'hF00, 11'h300);
    spd_case("spd_400_sat", 12'h400, 11'h7FF);
    spd_case("spd_bff_sat", 12'hBFF, 11'h000);

    // Mid-period speed change must not reach duty before the next synch.
    spd_case("hold_base", 12'h000, 11'h400);
    spd = 12'h7FF;
    ok  = 1'b1;
    for (int i = 0; i < 2047; i++) begin
      tick();
      if (duty !== 11'h400) ok = 1'b0;
    end
    check("hold_2047", int'(ok), 1);
    synch();
    check("hold_release", int'(duty), 'h7FF);

    // Over-current during blanking is ignored.
    ok = 1'b1;
    for (int p = 0; p < 20; p++) begin
      OVR_I_blank_n = 1'b0;
      OVR_I         = 1'b1;
      idle(12);
      OVR_I         = 1'b0;
      OVR_I_blank_n = 1'b1;
      synch();
      if (ovr_cnt !== 4'd0 || pwm_en !== 1'b1) ok = 1'b0;
    end
    check("blank_ignored", int'(ok), 1);
    check("blank_cnt", int'(ovr_cnt), 0);

    // Seven qualified periods then a clean one: counter clears, no trip.
    for (int p = 0; p < 3; p++) qual_period(1'b0);
    check("cnt_3", int'(ovr_cnt), 3);
    for (int p = 0; p < 4; p++) qual_period(1'b0);
    check("cnt_7", int'(ovr_cnt), 7);
    check("cnt_7_pwm_en", int'(pwm_en), 1);
    idle(5);
    synch();
    check("clean_clears", int'(ovr_cnt), 0);
    check("clean_no_trip", int'(pwm_en), 1);

    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("clr_in_run", int'(pwm_en), 1);

    // Eighth period's event lands on the synch clk itself.
    for (int p = 0; p < 7; p++) qual_period(1'b0);
    check("pre_trip_cnt", int'(ovr_cnt), 7);
    spd = 12'h7FF;
    qual_period(1'b1);
    check("trip_shtdwn", int'(OVR_I_shtdwn), 1);
    check("trip_pwm_en", int'(pwm_en), 0);
    check("trip_duty", int'(duty), 'h400);
    check("trip_cnt", int'(ovr_cnt), 0);

    qual_period(1'b0);
    check("fault_ignores_ovr", int'(ovr_cnt), 0);
    check("fault_holds_duty", int'(duty), 'h400);
    check("fault_stays", int'(OVR_I_shtdwn), 1);

    // clr_fault with synch on the same clk only reaches REARM.
    clr_fault = 1'b1;
    PWM_synch = 1'b1;
    tick();
    clr_fault = 1'b0;
    PWM_synch = 1'b0;
    check("rearm_shtdwn", int'(OVR_I_shtdwn), 1);
    check("rearm_pwm_en", int'(pwm_en), 0);
    idle(5);
    check("rearm_wait", int'(pwm_en), 0);
    check("rearm_duty", int'(duty), 'h400);
    spd = 12'h123;
    synch();
    check("rearm_run_pwm_en", int'(pwm_en), 1);
    check("rearm_run_shtdwn", int'(OVR_I_shtdwn), 0);
    check("rearm_run_duty", int'(duty), 'h523);

    // Reset out of FAULT.
    for (int p = 0; p < 8; p++) qual_period(1'b0);
    check("trip2_shtdwn", int'(OVR_I_shtdwn), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_fault_shtdwn", int'(OVR_I_shtdwn), 0);
    check("rst_fault_pwm_en", int'(pwm_en), 1);
    check("rst_fault_duty", int'(duty), 'h400);
    check("rst_fault_cnt", int'(ovr_cnt), 0);

    // Reset mid-period clears a pending over-current flag.
    idle(2);
    OVR_I = 1'b1;
    tick();
    OVR_I = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(3);
    check("rst_mid_duty", int'(duty), 'h400);
    synch();
    check("rst_seen_cleared", int'(ovr_cnt), 0);
    check("rst_first_synch_duty", int'(duty), 'h523);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
